pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_load_use.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared pipeline constants for the hazard controller: the FSM state
// encoding, the default divide latency and the width of the divide
// stall counter.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  // Hazard controller FSM states.
  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } hazard_state_e;

  // Default number of cycles a DIV/DIVU/REM/REMU occupies EX.
  localparam int DIV_CYCLES_DEFAULT = 32;

  // Width of the divide stall down-counter (covers DIV_CYCLES up to 63).
  localparam int DIV_CNT_WIDTH = 6;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// ---------------------------------------------------------------------------
// hazard_load_use_detect
// Purely combinational load-use comparator. Flags when the instruction in
// EX is a load writing a non-zero register that the instruction in ID
// actually reads on either source.
// Ports:
//   ID_RS1_ADDR, ID_RS2_ADDR  in  [4:0] sources of the ID instruction
//   ID_RS1_EN, ID_RS2_EN      in        source is really read
//   EX_REG_WRITE_ADDR         in  [4:0] destination of the EX instruction
//   EX_REG_WRITE_EN           in        EX instruction writes a register
//   EX_DATA_MEM_READ          in        EX instruction is a load
//   LOAD_USE                  out       load-use hazard present
// ---------------------------------------------------------------------------
module hazard_load_use_detect (
  input  logic [4:0] ID_RS1_ADDR,
  input  logic [4:0] ID_RS2_ADDR,
  input  logic       ID_RS1_EN,
  input  logic       ID_RS2_EN,
  input  logic [4:0] EX_REG_WRITE_ADDR,
  input  logic       EX_REG_WRITE_EN,
  input  logic       EX_DATA_MEM_READ,
  output logic       LOAD_USE
);

  logic ex_is_load_to_reg;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign ex_is_load_to_reg = EX_DATA_MEM_READ && EX_REG_WRITE_EN && (EX_REG_WRITE_ADDR != 5'd0);

  // A source only matters when the ID instruction really reads it.
  assign rs1_match = ID_RS1_EN && (ID_RS1_ADDR == EX_REG_WRITE_ADDR);
  assign rs2_match = ID_RS2_EN && (ID_RS2_ADDR == EX_REG_WRITE_ADDR);

  assign LOAD_USE = ex_is_load_to_reg && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for a five-stage pipeline. Produces per-register hold
// and bubble controls for data-memory stalls, multi-cycle divides, taken
// branches and load-use hazards, in that priority order.
// Ports:
//   CLK, RESET                in        clock, synchronous active-high reset
//   ID_RS1_ADDR/ID_RS2_ADDR   in  [4:0] ID instruction sources
//   ID_RS1_EN/ID_RS2_EN       in        ID instruction reads that source
//   EX_REG_WRITE_ADDR         in  [4:0] EX instruction destination
//   EX_REG_WRITE_EN           in        EX instruction writes a register
//   EX_DATA_MEM_READ          in        EX instruction is a load
//   EX_DIV_OP                 in        EX instruction is a divide/remainder
//   EX_BRANCH_TAKEN           in        taken branch/jump resolved in EX
//   MEM_DMEM_BUSY             in        data memory access not finished
//   PC/IF_ID/ID_EX/EX_MEM_HOLD           out  register keeps its value
//   IF_ID/ID_EX/EX_MEM/MEM_WB_BUBBLE     out  register loads a NOP
//   DIV_START                 out       one-cycle divider start pulse
//   DIV_BUSY                  out       divide stall in progress
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] ID_RS1_ADDR,
  input  logic [4:0] ID_RS2_ADDR,
  input  logic       ID_RS1_EN,
  input  logic       ID_RS2_EN,
  input  logic [4:0] EX_REG_WRITE_ADDR,
  input  logic       EX_REG_WRITE_EN,
  input  logic       EX_DATA_MEM_READ,
  input  logic       EX_DIV_OP,
  input  logic       EX_BRANCH_TAKEN,
  input  logic       MEM_DMEM_BUSY,
  output logic       PC_HOLD,
  output logic       IF_ID_HOLD,
  output logic       ID_EX_HOLD,
  output logic       EX_MEM_HOLD,
  output logic       IF_ID_BUBBLE,
  output logic       ID_EX_BUBBLE,
  output logic       EX_MEM_BUBBLE,
  output logic       MEM_WB_BUBBLE,
  output logic       DIV_START,
  output logic       DIV_BUSY
);

  // The start cycle is the first stall cycle and each counter value from
  // DIV_LOAD down to 1 adds one more, giving DIV_CYCLES held cycles before
  // the counter reaches 0 and the result is released.
  localparam logic [DIV_CNT_WIDTH-1:0] DIV_LOAD = DIV_CNT_WIDTH'(DIV_CYCLES - 1);

  hazard_state_e            state;
  logic [DIV_CNT_WIDTH-1:0] div_cnt;
  logic                     load_use;

  hazard_load_use_detect u_load_use (
    .ID_RS1_ADDR       (ID_RS1_ADDR),
    .ID_RS2_ADDR       (ID_RS2_ADDR),
    .ID_RS1_EN         (ID_RS1_EN),
    .ID_RS2_EN         (ID_RS2_EN),
    .EX_REG_WRITE_ADDR (EX_REG_WRITE_ADDR),
    .EX_REG_WRITE_EN   (EX_REG_WRITE_EN),
    .EX_DATA_MEM_READ  (EX_DATA_MEM_READ),
    .LOAD_USE          (load_use)
  );

  // Divide sequencing. A divide in EX while running loads the counter and
  // enters DIV_WAIT; the counter walks down to 0, and the zero cycle
  // returns to RUN without looking at EX_DIV_OP so the same divide cannot
  // restart itself. A busy data memory freezes everything, which stretches
  // the divide stall by exactly the busy cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= RUN;
      div_cnt <= '0;
    end else if (!MEM_DMEM_BUSY) begin
      case (state)
        RUN: begin
          if (EX_DIV_OP) begin
            state   <= DIV_WAIT;
            div_cnt <= DIV_LOAD;
          end
        end
        DIV_WAIT: begin
          if (div_cnt == '0) begin
            state <= RUN;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          div_cnt <= '0;
        end
      endcase
    end
  end

  // Priority-encoded hold/bubble generation. Each branch drives a disjoint
  // set of hold and bubble bits per register, so a register is never told
  // to hold and take a NOP at once. Branch and load-use handling only apply
  // while running; inside DIV_WAIT the divide owns the pipeline.
  always_comb begin
    PC_HOLD       = 1'b0;
    IF_ID_HOLD    = 1'b0;
    ID_EX_HOLD    = 1'b0;
    EX_MEM_HOLD   = 1'b0;
    IF_ID_BUBBLE  = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    MEM_WB_BUBBLE = 1'b0;
    DIV_START     = 1'b0;
    DIV_BUSY      = 1'b0;
    if (!RESET) begin
      DIV_BUSY = (state == DIV_WAIT);
      if (MEM_DMEM_BUSY) begin
        PC_HOLD       = 1'b1;
        IF_ID_HOLD    = 1'b1;
        ID_EX_HOLD    = 1'b1;
        EX_MEM_HOLD   = 1'b1;
        MEM_WB_BUBBLE = 1'b1;
      end else if (state == DIV_WAIT) begin
        if (div_cnt != '0) begin
          PC_HOLD       = 1'b1;
          IF_ID_HOLD    = 1'b1;
          ID_EX_HOLD    = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
        end
      end else if (EX_DIV_OP) begin
        DIV_START     = 1'b1;
        PC_HOLD       = 1'b1;
        IF_ID_HOLD    = 1'b1;
        ID_EX_HOLD    = 1'b1;
        EX_MEM_BUBBLE = 1'b1;
      end else if (EX_BRANCH_TAKEN) begin
        IF_ID_BUBBLE = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end else if (load_use) begin
        PC_HOLD      = 1'b1;
        IF_ID_HOLD   = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed self-checking bench for pipeline_hazard_ctrl. Outputs are packed
// into one vector, bit 9 down to 0:
//   PC_HOLD IF_ID_HOLD ID_EX_HOLD EX_MEM_HOLD IF_ID_BUBBLE ID_EX_BUBBLE
//   EX_MEM_BUBBLE MEM_WB_BUBBLE DIV_START DIV_BUSY
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] EXP_ZERO    = 10'b0000000000;
  localparam logic [9:0] EXP_LU      = 10'b1100010000;
  localparam logic [9:0] EXP_BR      = 10'b0000110000;
  localparam logic [9:0] EXP_DSTART  = 10'b1110001010;
  localparam logic [9:0] EXP_DWAIT   = 10'b1110001001;
  localparam logic [9:0] EXP_DREL    = 10'b0000000001;
  localparam logic [9:0] EXP_MBUSY   = 10'b1111000100;
  localparam logic [9:0] EXP_MBUSYDV = 10'b1111000101;

  logic       CLK;
  logic       RESET;
  logic [4:0] ID_RS1_ADDR;
  logic [4:0] ID_RS2_ADDR;
  logic       ID_RS1_EN;
  logic       ID_RS2_EN;
  logic [4:0] EX_REG_WRITE_ADDR;
  logic       EX_REG_WRITE_EN;
  logic       EX_DATA_MEM_READ;
  logic       EX_DIV_OP;
  logic       EX_BRANCH_TAKEN;
  logic       MEM_DMEM_BUSY;
  logic       PC_HOLD;
  logic       IF_ID_HOLD;
  logic       ID_EX_HOLD;
  logic       EX_MEM_HOLD;
  logic       IF_ID_BUBBLE;
  logic       ID_EX_BUBBLE;
  logic       EX_MEM_BUBBLE;
  logic       MEM_WB_BUBBLE;
  logic       DIV_START;
  logic       DIV_BUSY;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ID_RS1_ADDR       (ID_RS1_ADDR),
    .ID_RS2_ADDR       (ID_RS2_ADDR),
    .ID_RS1_EN         (ID_RS1_EN),
    .ID_RS2_EN         (ID_RS2_EN),
    .EX_REG_WRITE_ADDR (EX_REG_WRITE_ADDR),
    .EX_REG_WRITE_EN   (EX_REG_WRITE_EN),
    .EX_DATA_MEM_READ  (EX_DATA_MEM_READ),
    .EX_DIV_OP         (EX_DIV_OP),
    .EX_BRANCH_TAKEN   (EX_BRANCH_TAKEN),
    .MEM_DMEM_BUSY     (MEM_DMEM_BUSY),
    .PC_HOLD           (PC_HOLD),
    .IF_ID_HOLD        (IF_ID_HOLD),
    .ID_EX_HOLD        (ID_EX_HOLD),
    .EX_MEM_HOLD       (EX_MEM_HOLD),
    .IF_ID_BUBBLE      (IF_ID_BUBBLE),
    .ID_EX_BUBBLE      (ID_EX_BUBBLE),
    .EX_MEM_BUBBLE     (EX_MEM_BUBBLE),
    .MEM_WB_BUBBLE     (MEM_WB_BUBBLE),
    .DIV_START         (DIV_START),
    .DIV_BUSY          (DIV_BUSY)
  );

  assign obs = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
                IF_ID_BUBBLE, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE,
                DIV_START, DIV_BUSY};

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive every input for the coming cycle and let the combinational
  // outputs settle well clear of the next rising edge.
  task automatic applyStimulus(
    input logic       rst,
    input logic [4:0] rs1,
    input logic       rs1en,
    input logic [4:0] rs2,
    input logic       rs2en,
    input logic [4:0] exaddr,
    input logic       exwen,
    input logic       exrd,
    input logic       div,
    input logic       br,
    input logic       busy
  );
    RESET             = rst;
    ID_RS1_ADDR       = rs1;
    ID_RS1_EN         = rs1en;
    ID_RS2_ADDR       = rs2;
    ID_RS2_EN         = rs2en;
    EX_REG_WRITE_ADDR = exaddr;
    EX_REG_WRITE_EN   = exwen;
    EX_DATA_MEM_READ  = exrd;
    EX_DIV_OP         = div;
    EX_BRANCH_TAKEN   = br;
    MEM_DMEM_BUSY     = busy;
    #1;
  endtask

  // Compare the packed output vector against the hand-derived value.
  task automatic checkOutput(input string tag, input logic [9:0] expected);
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
    end
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with every hazard source active: outputs forced low.
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 1, 1);
    checkOutput("reset_forced_zero", EXP_ZERO);
    nextCycle();
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_reset", EXP_ZERO);
    nextCycle();

    // lw x5 in EX, ID reads x5 on rs1: one-cycle stall, then the bubble
    // reaches EX and the hazard is gone.
    applyStimulus(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0);
    checkOutput("load_use_rs1", EXP_LU);
    nextCycle();
    applyStimulus(0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("load_use_released", EXP_ZERO);
    nextCycle();

    // Load to x0 never stalls.
    applyStimulus(0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0);
    checkOutput("load_use_x0", EXP_ZERO);
    nextCycle();

    // rs2 match, rs2 match with rs2 unused, and a non-load producer.
    applyStimulus(0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 1, 0, 0, 0);
    checkOutput("load_use_rs2", EXP_LU);
    nextCycle();
    applyStimulus(0, 5'd3, 1, 5'd7, 0, 5'd7, 1, 1, 0, 0, 0);
    checkOutput("load_use_rs2_disabled", EXP_ZERO);
    nextCycle();
    applyStimulus(0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0);
    checkOutput("alu_producer_no_stall", EXP_ZERO);
    nextCycle();
    applyStimulus(0, 5'd7, 1, 5'd0, 0, 5'd7, 0, 1, 0, 0, 0);
    checkOutput("load_no_write_no_stall", EXP_ZERO);
    nextCycle();

    // Taken branch alone, and together with a load-use match.
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
    checkOutput("branch_only", EXP_BR);
    nextCycle();
    applyStimulus(0, 5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 0, 1, 0);
    checkOutput("branch_beats_load_use", EXP_BR);
    nextCycle();

    // Memory busy outranks a load-use match while running.
    applyStimulus(0, 5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 1);
    checkOutput("mem_busy_run", EXP_MBUSY);
    nextCycle();

    // Plain divide: start cycle (branch also raised, divide wins), 31
    // further stall cycles, release on cycle 33 with EX_DIV_OP still high.
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0);
    checkOutput("div_start", EXP_DSTART);
    nextCycle();
    for (int k = 2; k <= 32; k++) begin
      applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("div_wait_%0d", k), EXP_DWAIT);
      nextCycle();
    end
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checkOutput("div_release_33", EXP_DREL);
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("div_back_to_run", EXP_ZERO);
    nextCycle();

    // Divide with memory busy for cycles 10..12: total stall 35 cycles,
    // release on cycle 36.
    for (int k = 1; k <= 35; k++) begin
      if (k == 1) begin
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkOutput("divb_start", EXP_DSTART);
      end else if (k >= 10 && k <= 12) begin
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
        checkOutput($sformatf("divb_busy_%0d", k), EXP_MBUSYDV);
      end else begin
        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkOutput($sformatf("divb_wait_%0d", k), EXP_DWAIT);
      end
      nextCycle();
    end
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checkOutput("divb_release_36", EXP_DREL);
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("divb_back_to_run", EXP_ZERO);
    nextCycle();

    // Reset pulsed at divide cycle 5: the controller returns to RUN.
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checkOutput("divr_start", EXP_DSTART);
    nextCycle();
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("divr_wait_%0d", k), EXP_DWAIT);
      nextCycle();
    end
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checkOutput("divr_reset_cycle", EXP_ZERO);
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("divr_after_reset", EXP_ZERO);
    nextCycle();
    applyStimulus(0, 5'd4, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0);
    checkOutput("divr_run_load_use", EXP_LU);
    nextCycle();

    // Reset during memory busy, then normal operation.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    checkOutput("busy_reset_cycle", EXP_ZERO);
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checkOutput("busy_after_reset", EXP_ZERO);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
